// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Build option: DIV_EARLY_EXIT_EN (see seq_divider).
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = DIV_WIDTH;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StFix,
    StDone,
    StZero
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem < divisor <= 2^(WIDTH-1), so rem_sh fits and trial's MSB is a true sign bit.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - divisor;
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider (MIPS DIV semantics): quotient on lo, remainder on hi.
// Build option: define DIV_EARLY_EXIT_EN to skip the loop when |a| < |b|.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, rem_nx, quo_nx;
  logic [WIDTH:0]   dvs_q;
  logic             neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH:0]   mag_a, mag_b;
  logic             b_zero, early, accept;
  logic             unused_mag_msb;

  // Magnitudes are taken in WIDTH+1 bits so that |0x80000000| survives.
  always_comb begin
    mag_a  = a[WIDTH-1] ? -{a[WIDTH-1], a} : {1'b0, a};
    mag_b  = b[WIDTH-1] ? -{b[WIDTH-1], b} : {1'b0, b};
    b_zero = (b == '0);
    accept = (state_q == StIdle) && start;
`ifdef DIV_EARLY_EXIT_EN
    early  = (mag_a < mag_b);
`else
    early  = 1'b0;
`endif
  end

  assign unused_mag_msb = mag_a[WIDTH];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (b_zero)     state_d = StZero;
          else if (early) state_d = StFix;
          else            state_d = StRun;
        end
      end
      StRun:   if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      StZero:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept && !b_zero) begin
        cnt_q     <= '0;
        rem_q     <= early ? mag_a[WIDTH-1:0] : '0;
        quo_q     <= early ? '0 : mag_a[WIDTH-1:0];
        dvs_q     <= mag_b;
        neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_rem_q <= a[WIDTH-1];
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + 1'b1;
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end else if (state_q == StFix) begin
        lo_q <= neg_quo_q ? -quo_q : quo_q;
        hi_q <= neg_rem_q ? -rem_q : rem_q;
      end
    end
  end

  always_comb begin
    hi       = hi_q;
    lo       = lo_q;
    ready    = (state_q == StDone) || (state_q == StZero);
    div_zero = (state_q == StZero);
    busy     = (state_q != StIdle);
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
module tb_seq_divider;

  localparam int LatFull = 34;
`ifdef DIV_EARLY_EXIT_EN
  localparam int LatShort = 2;
`else
  localparam int LatShort = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        ready, div_zero, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH (32)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .ready    (ready),
    .div_zero (div_zero),
    .busy     (busy)
  );

  // Edge count n includes the accept edge as 1; outputs sampled on the falling edge.
  task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input bit stray,
                        output int lat, output bit dz, output bit busy_ok, output bit after_ok);
    int n;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'h5555_5555; b = 32'h0;
    n = 1; lat = -1; dz = 1'b0; busy_ok = 1'b1; after_ok = 1'b0;
    while (n <= 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ready === 1'b1) begin
        lat = n;
        dz  = div_zero;
        break;
      end
      if (stray && n == 9) begin
        start = 1'b1; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      after_ok = (ready === 1'b0) && (busy === 1'b0) && (div_zero === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    n_cmp++;
    if ({hi, lo, ready, div_zero, busy} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got hi=%h lo=%h rdy=%b dz=%b busy=%b want all zero",
               hi, lo, ready, div_zero, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; bit dz, bok, aok;
    do_div(32'd100, 32'd7, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lat !== LatFull) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, LatFull); end
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL basic_lo: got %h want %h", lo, 32'd14); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL basic_hi: got %h want %h", hi, 32'd2); end
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL basic_dz: got %b want 0", dz); end
    n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", bok); end
    n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL basic_pulse: got %b want 1", aok); end
  endtask

  task automatic test_signs();
    int lat; bit dz, bok, aok;
    do_div(32'hFFFF_FF9C, 32'd7, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lo !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL negdvd_lo: got %h want fffffff2", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL negdvd_hi: got %h want fffffffe", hi); end
    do_div(32'd100, 32'hFFFF_FFF9, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lo !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL negdvs_lo: got %h want fffffff2", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL negdvs_hi: got %h want 00000002", hi); end
    do_div(32'hFFFF_FFFD, 32'd7, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lat !== LatShort) begin n_err++; $display("FAIL small_latency: got %0d want %0d", lat, LatShort); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL small_lo: got %h want 00000000", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL small_hi: got %h want fffffffd", hi); end
  endtask

  task automatic test_overflow();
    int lat; bit dz, bok, aok;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ovf_hi: got %h want 00000000", hi); end
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL ovf_dz: got %b want 0", dz); end
  endtask

  task automatic test_div_zero();
    int lat; bit dz, bok, aok;
    do_div(32'd9, 32'd4, 1'b0, lat, dz, bok, aok);
    n_cmp++; if ({hi, lo} !== {32'd1, 32'd2}) begin n_err++; $display("FAIL preload: got hi=%h lo=%h want 1/2", hi, lo); end
    do_div(32'd5, 32'd0, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", dz); end
    n_cmp++; if ({hi, lo} !== {32'd1, 32'd2}) begin n_err++; $display("FAIL zero_hold: got hi=%h lo=%h want 1/2", hi, lo); end
    n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL zero_pulse: got %b want 1", aok); end
  endtask

  task automatic test_busy_ignore();
    int lat; bit dz, bok, aok;
    do_div(32'd100, 32'd7, 1'b1, lat, dz, bok, aok);
    n_cmp++; if (lat !== LatFull) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", lat, LatFull); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL ignore_result: got hi=%h lo=%h want 2/14", hi, lo); end
    n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL ignore_pulse: got %b want 1", aok); end
  endtask

  task automatic test_reset_abort();
    int lat; bit dz, bok, aok, quiet;
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hi, lo, ready, div_zero, busy} !== 67'd0) begin
      n_err++;
      $display("FAIL abort_clear: got hi=%h lo=%h rdy=%b dz=%b busy=%b want all zero",
               hi, lo, ready, div_zero, busy);
    end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ready !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (ready !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL abort_no_ready: got %b want 1", quiet); end
    do_div(32'd20, 32'd6, 1'b0, lat, dz, bok, aok);
    n_cmp++; if (lat !== LatFull) begin n_err++; $display("FAIL after_abort_latency: got %0d want %0d", lat, LatFull); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd3}) begin n_err++; $display("FAIL after_abort_result: got hi=%h lo=%h want 2/3", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
